bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of bus cycles to wait for bus_ack_i before aborting (range 1..255).
REQ-002 SHALL have ports `clk` (input, 1 bit), the single clock, and `rst` (input, 1 bit), an asynchronous active-low reset.
REQ-003 SHALL have ports `if_req_i` (in, 1), instruction-fetch request, and `if_addr_i` (in, 32), fetch address.
REQ-004 SHALL have ports `if_data_o` (out, 32), fetched instruction, and `if_ack_o` (out, 1), one-cycle completion pulse.
REQ-005 SHALL have ports `mem_req_i` (in, 1), data request; `mem_we_i` (in, 1), 1 = write; `mem_sel_i` (in, 4), byte enables; `mem_addr_i` (in, 32); `mem_data_i` (in, 32), write data.
REQ-006 SHALL have ports `mem_data_o` (out, 32), read data, and `mem_ack_o` (out, 1), one-cycle completion pulse.
REQ-007 SHALL have ports `stallreq_if_o` and `stallreq_mem_o` (out, 1 each), stall requests to the pipeline controller.
REQ-008 SHALL have port `flush_i` (in, 1), a pipeline flush that discards any pending result.
REQ-009 SHALL have bus outputs `bus_req_o` (1), `bus_we_o` (1), `bus_sel_o` (4), `bus_addr_o` (32) and `bus_data_o` (32).
REQ-010 SHALL have bus inputs `bus_data_i` (32) and `bus_ack_i` (1).
REQ-011 SHALL have port `bus_timeout_o` (out, 1), a sticky timeout flag.

Function
REQ-012 SHALL implement a state machine with states IDLE, BUSY_IF, BUSY_MEM, DONE_IF and DONE_MEM.
REQ-013 In IDLE with flush_i=0, SHALL grant on the next edge: mem_req_i goes to BUSY_MEM, otherwise if_req_i goes to BUSY_IF, otherwise the FSM stays in IDLE.
REQ-014 SHALL grant IF instead of MEM when both are requesting and the mem-streak counter equals 4; the counter counts consecutive MEM grants while if_req_i=1, and clears on any IF grant.
REQ-015 On grant, SHALL register bus_addr_o, bus_we_o, bus_sel_o and bus_data_o from the winning requester, and hold them stable with bus_req_o=1 for the whole BUSY state.
REQ-016 For IF grants, SHALL drive bus_we_o=0 and bus_sel_o=4'hF.
REQ-017 In BUSY, on bus_ack_i=1, SHALL capture bus_data_i into the matching data output, drop bus_req_o and go to DONE on the next edge.
REQ-018 In BUSY, SHALL increment a wait counter every cycle; when it reaches TIMEOUT with no ack, SHALL drop bus_req_o, load data 32'h0, set bus_timeout_o and go to DONE.
REQ-019 In DONE_IF / DONE_MEM, SHALL assert if_ack_o / mem_ack_o for exactly one cycle and then return to IDLE.
REQ-020 Data outputs SHALL hold their last captured value until the next capture.
REQ-021 SHALL drive stallreq_if_o = if_req_i AND NOT (state==DONE_IF), combinationally; stallreq_mem_o SHALL follow the same rule with DONE_MEM.
REQ-022 Minimum latency SHALL be: request in cycle 0, bus_req_o in cycle 1, ack in cycle 1, DONE in cycle 2 (3 cycles request to ack).
REQ-023 If flush_i=1 during BUSY, the bus transaction SHALL still run to ack or timeout, then the FSM SHALL go straight to IDLE with no requester ack and no data-output update.
REQ-024 If flush_i=1 in IDLE, SHALL make no grant that cycle.
REQ-025 If flush_i=1 in DONE, the ack pulse SHALL be suppressed.
REQ-026 A bus_ack_i arriving outside BUSY SHALL be ignored.
REQ-027 Requests withdrawn during BUSY SHALL NOT abort the bus transaction.
REQ-028 bus_timeout_o SHALL stay set until reset.

Reset
REQ-029 When rst=0, asynchronously, SHALL force state=IDLE, all counters=0, every 1-bit output 0 (stall requests included) and every multi-bit output to zero.
REQ-030 SHALL leave reset synchronously on the first clk edge after rst returns high.
REQ-031 A reset asserted mid-transaction SHALL drop bus_req_o immediately, with no ack produced.

Verification
REQ-032 IF-only test: if_req_i=1, addr 0x100, zero-wait memory returns 0x3C011234 -> bus_req_o high in cycle 1, if_ack_o pulse in cycle 2, if_data_o=0x3C011234, stallreq_if_o low in cycle 2 only.
REQ-033 Simultaneous test: mem write (addr 0x20, data 0xDEADBEEF, sel 4'b0011) plus IF request -> mem granted first; IF granted after DONE_MEM; both acks seen in order.
REQ-034 Starvation test: mem_req_i and if_req_i held high for 20 cycles -> IF granted after exactly 4 consecutive MEM grants.
REQ-035 Timeout test: TIMEOUT=8, bus_ack_i never asserted -> bus_req_o high for 8 cycles, then bus_timeout_o=1, ack pulse with data 0x00000000.
REQ-036 Flush test: flush_i pulsed during a 5-wait-state BUSY_IF -> bus completes, no if_ack_o, if_data_o unchanged, FSM back in IDLE.
REQ-037 Reset test: rst driven low during BUSY_MEM, between clock edges -> bus_req_o and all outputs 0 immediately; the first request after reset behaves as in REQ-032.

Source files
------------

// File: rtl/bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bus_arbiter                                                |
// | Description : Arbitrates one external bus between an instruction-fetch   |
// |               port and a data-memory port. Data requests win by default; |
// |               after four back-to-back data grants with fetch waiting,    |
// |               fetch is served once. Each bus cycle is bounded by TIMEOUT |
// |               clocks, after which it is aborted and a sticky flag set.   |
// |                                                                          |
// | Parameters  : TIMEOUT        max busy cycles awaiting bus_ack_i (1..255) |
// | Ports       : clk, rst       clock, async active-low reset               |
// |               if_*           fetch request/address, data/ack back        |
// |               mem_*          data request (we, sel, addr, wdata),        |
// |                              read data/ack back                          |
// |               stallreq_*_o   stall requests to the pipeline controller   |
// |               flush_i        discard any pending result                  |
// |               bus_*          external bus master signals                 |
// |               bus_timeout_o  sticky timeout flag                         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module bus_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_ack_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        mem_ack_o,
    output logic        stallreq_if_o,
    output logic        stallreq_mem_o,
    input  logic        flush_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_data_o,
    input  logic [31:0] bus_data_i,
    input  logic        bus_ack_i,
    output logic        bus_timeout_o
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_BUSY_IF  = 3'd1;
    localparam logic [2:0] S_BUSY_MEM = 3'd2;
    localparam logic [2:0] S_DONE_IF  = 3'd3;
    localparam logic [2:0] S_DONE_MEM = 3'd4;

    // Wait counter starts at 0 on grant, so the last allowed busy cycle
    // is the one where it holds TIMEOUT-1.
    localparam logic [7:0] c_wait_last  = 8'(TIMEOUT - 1);
    localparam logic [2:0] c_streak_max = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [2:0]  r_streak;
    logic [7:0]  r_wait_cnt;
    logic        r_flush_pend;
    logic        r_bus_we;
    logic [3:0]  r_bus_sel;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_data;
    logic [31:0] r_if_data;
    logic [31:0] r_mem_data;
    logic        r_bus_timeout;

    logic        w_busy;
    logic        w_grant_mem;
    logic        w_grant_if;
    logic        w_timeout;
    logic        w_finish;
    logic        w_discard;
    logic [31:0] w_rdata;

    assign w_busy  = (r_state == S_BUSY_IF) || (r_state == S_BUSY_MEM);
    assign w_rdata = w_timeout ? 32'h0 : bus_data_i;

    // ------------------------------------------------------------------
    // Next-state and grant decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant_mem = 1'b0;
        w_grant_if  = 1'b0;
        w_timeout   = 1'b0;
        w_finish    = 1'b0;
        w_discard   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!flush_i) begin
                    // Data wins unless fetch has waited through a full streak.
                    if (mem_req_i && !(if_req_i && (r_streak == c_streak_max))) begin
                        w_grant_mem = 1'b1;
                        w_state_nxt = S_BUSY_MEM;
                    end else if (if_req_i) begin
                        w_grant_if  = 1'b1;
                        w_state_nxt = S_BUSY_IF;
                    end
                end
            end
            S_BUSY_IF, S_BUSY_MEM: begin
                w_timeout = !bus_ack_i && (r_wait_cnt == c_wait_last);
                w_finish  = bus_ack_i || w_timeout;
                // A flush seen at any point of the bus cycle discards its result.
                w_discard = r_flush_pend || flush_i;
                if (w_finish) begin
                    if (w_discard) begin
                        w_state_nxt = S_IDLE;
                    end else if (r_state == S_BUSY_IF) begin
                        w_state_nxt = S_DONE_IF;
                    end else begin
                        w_state_nxt = S_DONE_MEM;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Bus request registers, counters and captured read data
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_streak      <= 3'd0;
            r_wait_cnt    <= 8'd0;
            r_flush_pend  <= 1'b0;
            r_bus_we      <= 1'b0;
            r_bus_sel     <= 4'h0;
            r_bus_addr    <= 32'h0;
            r_bus_data    <= 32'h0;
            r_if_data     <= 32'h0;
            r_mem_data    <= 32'h0;
            r_bus_timeout <= 1'b0;
        end else begin
            if (w_grant_mem) begin
                r_bus_we   <= mem_we_i;
                r_bus_sel  <= mem_sel_i;
                r_bus_addr <= mem_addr_i;
                r_bus_data <= mem_data_i;
                // Only a grant that made fetch wait extends the streak.
                r_streak   <= if_req_i ? (r_streak + 3'd1) : 3'd0;
            end else if (w_grant_if) begin
                r_bus_we   <= 1'b0;
                r_bus_sel  <= 4'hF;
                r_bus_addr <= if_addr_i;
                r_bus_data <= 32'h0;
                r_streak   <= 3'd0;
            end

            if (w_grant_mem || w_grant_if) begin
                r_wait_cnt   <= 8'd0;
                r_flush_pend <= 1'b0;
            end else if (w_busy) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
                if (flush_i) begin
                    r_flush_pend <= 1'b1;
                end
            end

            if (w_timeout) begin
                r_bus_timeout <= 1'b1;
            end

            if (w_finish && !w_discard) begin
                if (r_state == S_BUSY_IF) begin
                    r_if_data <= w_rdata;
                end else begin
                    r_mem_data <= w_rdata;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus_req_o     = w_busy;
    assign bus_we_o      = r_bus_we;
    assign bus_sel_o     = r_bus_sel;
    assign bus_addr_o    = r_bus_addr;
    assign bus_data_o    = r_bus_data;
    assign bus_timeout_o = r_bus_timeout;
    assign if_data_o     = r_if_data;
    assign mem_data_o    = r_mem_data;

    assign if_ack_o  = (r_state == S_DONE_IF)  && !flush_i;
    assign mem_ack_o = (r_state == S_DONE_MEM) && !flush_i;

    // Stall requests are combinational from the request lines, so they are
    // gated by reset explicitly to read 0 while rst is low.
    assign stallreq_if_o  = rst && if_req_i  && (r_state != S_DONE_IF);
    assign stallreq_mem_o = rst && mem_req_i && (r_state != S_DONE_MEM);

endmodule
`default_nettype wire
